// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------
// Round-robin arbiter that lets NREQ producers take turns writing into one
// shared FIFO. In IDLE it picks the next producer with valid data, scanning
// circularly from the producer after the last grant holder. In XFER it gives
// that producer the FIFO for up to BURST words. It then returns to IDLE for
// exactly one cycle before the next grant.
//
// Ports
//   clock      sole clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  [NREQ]         producer i has a word
//   req_data   [NREQ*DWIDTH]  producer i word at [i*DWIDTH +: DWIDTH]
//   req_ready  [NREQ]         producer i word accepted this cycle
//   fifo_full  FIFO full flag
//   fifo_wr    FIFO write strobe (combinational from the grant holder)
//   fifo_din   [DWIDTH]       FIFO write data, zero outside XFER
//   owner      [clog2(NREQ)]  current grant holder, valid while busy
//   busy       high while a grant is active (XFER)
//   wr_count   [16]           total words written, wraps at 0xFFFF
module fifo_wr_arbiter #(
  parameter  int DWIDTH = 8,
  parameter  int NREQ   = 4,
  parameter  int BURST  = 4,
  localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr,
  output logic [DWIDTH-1:0]      fifo_din,
  output logic [OW-1:0]          owner,
  output logic                   busy,
  output logic [15:0]            wr_count
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   rr_q;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   beat_d;
  logic [15:0]     wr_count_q;
  logic [15:0]     wr_count_d;
  logic [OW-1:0]   pick;
  logic            xfer;
  logic            own_valid;

  assign xfer       = (state_q == XFER);
  assign own_valid  = req_valid[owner_q];
  assign beat_d     = beat_q + 1'b1;
  assign wr_count_d = wr_count_q + 16'd1;

  // Circular scan starting at rr_q+1. Walking from the farthest distance
  // down to the nearest lets the nearest valid requester win last.
  always_comb begin
    int idx;
    idx  = 0;
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (req_valid[idx]) pick = OW'(idx);
    end
  end

  // The write path is combinational so a producer sees acceptance in the
  // same cycle it presents data.
  assign fifo_wr  = xfer && own_valid && !fifo_full;
  assign fifo_din = xfer ? req_data[int'(owner_q)*DWIDTH +: DWIDTH] : '0;
  assign owner    = owner_q;
  assign busy     = xfer;
  assign wr_count = wr_count_q;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = xfer && !fifo_full && (owner_q == OW'(gi));
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= OW'(NREQ - 1);   // requester 0 wins the first scan
      owner_q    <= '0;
      beat_q     <= '0;
      wr_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            owner_q <= pick;
            beat_q  <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (!own_valid) begin
            // The grant is dropped as soon as the owner stops supplying
            // data, even while the FIFO is full.
            state_q <= IDLE;
            rr_q    <= owner_q;
          end else if (fifo_wr) begin
            wr_count_q <= wr_count_d;
            if (beat_q == BW'(BURST - 1)) begin
              state_q <= IDLE;
              rr_q    <= owner_q;
            end else begin
              beat_q <= beat_d;
            end
          end
          // The FIFO is full while the owner is still valid: hold
          // everything and wait with no timeout.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic            clock = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic            fifo_full;
  logic [NREQ-1:0] req_ready;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      owner;
  logic            busy;
  logic [15:0]     wr_count;

  // Second instance with a long burst, used only for the counter wrap.
  logic            w_rst;
  logic [NREQ-1:0] w_valid;
  logic [NREQ*DW-1:0] w_data;
  logic            w_full;
  logic [NREQ-1:0] w_ready;
  logic            w_wr;
  logic [DW-1:0]   w_din;
  logic [1:0]      w_owner;
  logic            w_busy;
  logic [15:0]     w_count;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(NREQ), .BURST(BURST)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_din(fifo_din), .owner(owner), .busy(busy), .wr_count(wr_count)
  );

  fifo_wr_arbiter #(.DWIDTH(DW), .NREQ(NREQ), .BURST(256)) u_wrap (
    .clock(clock), .rst(w_rst), .req_valid(w_valid), .req_data(w_data),
    .req_ready(w_ready), .fifo_full(w_full), .fifo_wr(w_wr),
    .fifo_din(w_din), .owner(w_owner), .busy(w_busy), .wr_count(w_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_busy, m_owner, m_rr, m_beats;
  logic [15:0] m_count;
  bit          log_grants = 0;
  bit          fifo_mode  = 0;
  bit          prev_busy  = 0;
  int          grants[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wlog[$];
  logic [NREQ-1:0] acc_mask = '0;
  int          pops = 0;
  int          full_seen = 0;

  function automatic int pick_next(input int rr, input logic [NREQ-1:0] v);
    for (int d = 1; d <= NREQ; d++) begin
      if (v[(rr + d) % NREQ]) return (rr + d) % NREQ;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_owner = 0; m_rr = NREQ - 1; m_beats = 0; m_count = 16'd0;
  endtask

  initial begin : compare
    logic            exp_wr;
    logic [NREQ-1:0] exp_ready;
    logic [DW-1:0]   exp_din;
    logic [DW-1:0]   got;
    int              n;
    m_reset();
    forever begin
      @(negedge clock);
      if (rst) m_reset();
      exp_wr    = (m_busy != 0) && req_valid[m_owner] && !fifo_full;
      exp_ready = (m_busy != 0 && !fifo_full) ? (NREQ'(1) << m_owner) : '0;
      exp_din   = (m_busy != 0) ? req_data[m_owner*DW +: DW] : '0;
      chk("busy",      32'(busy),      32'(m_busy != 0));
      chk("fifo_wr",   32'(fifo_wr),   32'(exp_wr));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("fifo_din",  32'(fifo_din),  32'(exp_din));
      chk("wr_count",  32'(wr_count),  32'(m_count));
      if (m_busy != 0) chk("owner", 32'(owner), 32'(m_owner));
      if (log_grants && busy && !prev_busy) grants.push_back(int'(owner));
      prev_busy = busy;
      acc_mask  = req_ready & req_valid;
      if (fifo_mode) begin
        if (fifo_full) full_seen++;
        chk("no_write_full", 32'(fifo_wr & fifo_full), 32'd0);
        if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) begin
          got = fifo_q.pop_front();
          pops++;
          if (wlog.size() == 0) chk("fifo_order_log_empty", 32'(got), 32'hFFFF_FFFF);
          else chk("fifo_order", 32'(got), 32'(wlog.pop_front()));
        end
        if (fifo_wr) fifo_q.push_back(fifo_din);
        if (exp_wr)  wlog.push_back(exp_din);
      end
      @(posedge clock);
      if (rst) begin
        m_reset();
      end else if (m_busy == 0) begin
        n = pick_next(m_rr, req_valid);
        if (n >= 0) begin
          m_busy = 1; m_owner = n; m_beats = 0;
        end
      end else if (!req_valid[m_owner]) begin
        m_busy = 0; m_rr = m_owner;
      end else if (!fifo_full) begin
        m_count = m_count + 16'd1;
        m_beats++;
        if (m_beats == BURST) begin
          m_busy = 0; m_rr = m_owner;
        end
      end
    end
  end

  // ---------------- wrap counter test ----------------
  int w_writes = 0;
  bit wrap_done = 0;

  initial begin : wr_counter
    forever begin
      @(negedge clock);
      if (w_wr) w_writes++;
    end
  end

  initial begin : wrap_stim
    int cyc;
    w_rst = 1'b1; w_valid = '0; w_data = 32'hA5A5_A5A5; w_full = 1'b0;
    step(2);
    w_rst = 1'b0;
    w_valid = 4'b0001;
    cyc = 0;
    while (w_writes < 32'hFFFE && cyc < 80000) begin step(); cyc++; end
    w_valid = '0;
    chk("wrap_preload", 32'(w_count), 32'h0000_FFFE);
    step();
    w_valid = 4'b0001;
    while (w_writes < 32'h1_0001 && cyc < 80000) begin step(); cyc++; end
    w_valid = '0;
    chk("wrap_writes", 32'(w_writes), 32'h0001_0001);
    chk("wrap_count",  32'(w_count),  32'h0000_0001);
    wrap_done = 1;
  end

  // ---------------- directed stimulus ----------------
  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin : main
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    step(1);
    chk("reset_busy",     32'(busy),      32'd0);
    chk("reset_fifo_wr",  32'(fifo_wr),   32'd0);
    chk("reset_ready",    32'(req_ready), 32'd0);
    chk("reset_wr_count", 32'(wr_count),  32'd0);
    chk("reset_din",      32'(fifo_din),  32'd0);
    step(1);
    rst = 1'b0;

    // All four requesters valid: round-robin 0,1,2,3,0 with 4 words each.
    log_grants = 1;
    req_valid  = 4'hF;
    repeat (20) begin req_data = $urandom; step(); end
    chk("rr_count16", 32'(wr_count), 32'd16);
    chk("rr_idle_gap", 32'(busy), 32'd0);
    step(2);
    log_grants = 0;
    chk("rr_grant_num", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5 && i < grants.size(); i++)
      chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(exp_order[i]));

    // Only requester 2, two words then valid drops; then 1 and 2 -> 1.
    do_reset();
    req_valid = 4'b0100;
    req_data = $urandom; step();
    req_data = $urandom; step();
    req_data = $urandom; step();
    req_valid = '0;
    step();
    chk("drop_count2", 32'(wr_count), 32'd2);
    chk("drop_idle",   32'(busy),     32'd0);
    req_valid = 4'b0110;
    step();
    chk("drop_regrant_busy",  32'(busy),  32'd1);
    chk("drop_regrant_owner", 32'(owner), 32'd1);

    // Requester 0 stalled by a full FIFO for 5 cycles after its first word.
    do_reset();
    req_valid = 4'b0001;
    step(2);
    chk("stall_first", 32'(wr_count), 32'd1);
    fifo_full = 1'b1;
    repeat (5) begin
      #1;
      chk("stall_wr",    32'(fifo_wr),   32'd0);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_busy",  32'(busy),      32'd1);
      step();
    end
    fifo_full = 1'b0;
    step(3);
    chk("stall_total", 32'(wr_count), 32'd4);
    chk("stall_exit",  32'(busy),     32'd0);
    req_valid = '0;

    // Reset during the second beat of a burst.
    do_reset();
    req_valid = 4'b0001;
    step(2);
    chk("midrst_pre_wr", 32'(fifo_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_wr",    32'(fifo_wr),  32'd0);
    chk("midrst_busy",  32'(busy),     32'd0);
    chk("midrst_count", 32'(wr_count), 32'd0);
    step(1);
    rst = 1'b0;
    req_valid = 4'hF;
    step();
    chk("midrst_grant_busy",  32'(busy),  32'd1);
    chk("midrst_grant_owner", 32'(owner), 32'd0);

    // Streaming into a depth-16 FIFO with a random reader.
    do_reset();
    fifo_mode = 1;
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_data[i*DW +: DW] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      fifo_full = (fifo_q.size() >= 16);
      step();
    end
    req_valid = '0;
    repeat (200) begin
      fifo_full = (fifo_q.size() >= 16);
      step();
    end
    fifo_mode = 0;
    chk("fifo_drained",   32'(fifo_q.size()), 32'd0);
    chk("fifo_log_empty", 32'(wlog.size()),   32'd0);
    chk("fifo_filled",    32'(full_seen > 0), 32'd1);
    chk("fifo_reads",     32'(pops > 50),     32'd1);

    wait (wrap_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DWIDTH, default 8, FIFO data width.
REQ-002 Parameter NREQ, default 4, number of producers.
REQ-003 Parameter BURST, default 4, maximum words per grant.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 req_valid  input  NREQ  bit i: producer i has a word.
REQ-008 req_data  input  NREQ*DWIDTH  producer i word at bits [i*DWIDTH +: DWIDTH].
REQ-009 req_ready  output  NREQ  bit i: producer i word accepted this cycle when req_valid[i] is high.
REQ-010 fifo_full  input  1  FIFO full flag.
REQ-011 fifo_wr  output  1  FIFO write strobe.
REQ-012 fifo_din  output  DWIDTH  FIFO write data.
REQ-013 owner  output  clog2(NREQ)  current grant holder; valid only while busy.
REQ-014 busy  output  1  high in state XFER.
REQ-015 wr_count  output  16  total words written, wraps 0xFFFF->0.

Function
REQ-016 The FSM SHALL have two states: IDLE and XFER.
REQ-017 IDLE: if any req_valid is high, the block SHALL register owner = first set bit scanning circularly from rr_ptr+1, clear beat_cnt, and enter XFER next cycle; otherwise it stays in IDLE.
REQ-018 IDLE SHALL not depend on fifo_full for arbitration.
REQ-019 In XFER: req_ready[owner] = !fifo_full; all other req_ready bits = 0.
REQ-020 In XFER: fifo_wr = req_valid[owner] && !fifo_full, combinational, zero latency.
REQ-021 In XFER: fifo_din = req_data[owner]; in IDLE, fifo_din = 0.
REQ-022 Each write SHALL increment beat_cnt and wr_count by 1.
REQ-023 XFER->IDLE when a write occurs with beat_cnt == BURST-1.
REQ-024 XFER->IDLE when req_valid[owner] is low in any cycle.
REQ-025 On every XFER exit, rr_ptr SHALL be set to owner.
REQ-026 While fifo_full is high in XFER: no write; beat_cnt holds; the state stays XFER with no timeout.
REQ-027 When fifo_full is high and req_valid[owner] is low in the same cycle, REQ-024 applies and the block exits.
REQ-028 There SHALL be exactly one IDLE cycle between consecutive grants.
REQ-029 A requester dropping and re-raising valid SHALL not retain priority.
REQ-030 Outside XFER, fifo_wr and req_ready SHALL be 0.

Reset
REQ-031 On rst: state = IDLE, rr_ptr = NREQ-1 (requester 0 wins first), owner = 0, beat_cnt = 0, wr_count = 0.
REQ-032 On rst, all outputs SHALL be 0 immediately, without waiting for a clock edge.
REQ-033 Reset asserted mid-burst SHALL drop fifo_wr in the same cycle; no partial state survives.

Verification
REQ-034 Reset, then req_valid=4'b1111 held, fifo_full=0 -> grants in order 0,1,2,3,0; each grant gives 4 writes followed by 1 IDLE cycle; wr_count=16 after 4 grants.
REQ-035 Only req 2 valid, 2 words then valid drops -> 2 writes with data matching; exit to IDLE; next grant with reqs 1 and 2 valid goes to 3->...: scan from 3 selects req 1 (after 3,0).
REQ-036 Req 0 in XFER, fifo_full asserted for 5 cycles after 1 word -> fifo_wr=0 and req_ready=0 for those 5 cycles; then 3 more words; total 4; no overflow.
REQ-037 Assert rst during beat 2 of a burst -> fifo_wr=0, busy=0 and wr_count=0 immediately; after release, req 0 is granted first.
REQ-038 Preload wr_count to 0xFFFE by 0xFFFE writes, then 3 writes -> wr_count = 0x0001.
REQ-039 Connect to the FIFO with depth 16 and 4 producers streaming random data; the scoreboard checks the read order equals the grant-order write log; no write occurs while full.
